// File: rtl/arc4_encrypt_if.sv
// Bus bundle between the ARC4 encryptor and its host and memories:
// start/ready handshake, key, plaintext read port and ciphertext write port.
interface arc4_encrypt_if;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  pt_addr;
   logic [7:0]  pt_rddata;
   logic [7:0]  ct_addr;
   logic [7:0]  ct_wrdata;
   logic        ct_wren;

   // Encryptor side
   modport slave (
      input  en, key, pt_rddata,
      output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
   );

   // Host / memory side
   modport master (
      output en, key, pt_rddata,
      input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
   );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor with a fixed 3-byte key. It reads a length-prefixed
// plaintext and writes a length-prefixed ciphertext. The S box is a
// 256x8 RAM with a registered read port, and every swap is split into
// read/read/write/write cycles so that only one write happens per cycle.
module arc4_encrypt (
   input  logic           clk,
   input  logic           rst_n,
   arc4_encrypt_if.slave  bus
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_INIT,
      ST_K1, ST_K2, ST_K3, ST_K4,
      ST_L1, ST_L2,
      ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_P6
   } state_t;

   state_t      r_state, w_next;
   logic        r_rdy;
   logic [23:0] r_key;
   logic [7:0]  r_i, r_j, r_k, r_len, r_si, r_sj, r_pt;
   logic [1:0]  r_kidx;

   logic [7:0]  r_s [0:255];
   logic [7:0]  r_s_rdata;

   logic        w_s_we;
   logic [7:0]  w_s_waddr, w_s_wdata, w_s_raddr;
   logic [7:0]  w_keybyte, w_j_ksa, w_j_prga, w_i_inc, w_pad_addr;
   logic        w_ct_wren;
   logic [7:0]  w_ct_addr, w_ct_wrdata, w_pt_addr;

   assign w_keybyte  = (r_kidx == 2'd0) ? r_key[23:16] :
                       (r_kidx == 2'd1) ? r_key[15:8]  : r_key[7:0];
   assign w_j_ksa    = r_j + r_s_rdata + w_keybyte;
   assign w_j_prga   = r_j + r_s_rdata;
   assign w_i_inc    = r_i + 8'd1;
   // The sum is the same before and after the swap, so the pre-swap copies are used.
   assign w_pad_addr = r_si + r_sj;

   // State register; rdy is registered so it stays low throughout reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rdy   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_rdy   <= (w_next == ST_IDLE);
      end
   end

   // Next-state sequencing of the init, key-schedule, length and keystream phases.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (r_rdy && bus.en) w_next = ST_INIT;
         ST_INIT: if (r_i == 8'hFF) w_next = ST_K1;
         ST_K1:   w_next = ST_K2;
         ST_K2:   w_next = ST_K3;
         ST_K3:   w_next = ST_K4;
         ST_K4:   w_next = (r_i == 8'hFF) ? ST_L1 : ST_K1;
         ST_L1:   w_next = ST_L2;
         ST_L2:   w_next = (bus.pt_rddata == 8'd0) ? ST_IDLE : ST_P1;
         ST_P1:   w_next = ST_P2;
         ST_P2:   w_next = ST_P3;
         ST_P3:   w_next = ST_P4;
         ST_P4:   w_next = ST_P5;
         ST_P5:   w_next = ST_P6;
         ST_P6:   w_next = (r_k == r_len) ? ST_IDLE : ST_P1;
         default: w_next = ST_IDLE;
      endcase
   end

   // Per-state S-RAM strobes and memory-port outputs; everything is zero outside its state.
   always_comb begin
      w_s_we      = 1'b0;
      w_s_waddr   = 8'd0;
      w_s_wdata   = 8'd0;
      w_s_raddr   = 8'd0;
      w_ct_wren   = 1'b0;
      w_ct_addr   = 8'd0;
      w_ct_wrdata = 8'd0;
      w_pt_addr   = 8'd0;
      case (r_state)
         ST_INIT: begin
            w_s_we    = 1'b1;
            w_s_waddr = r_i;
            w_s_wdata = r_i;
         end
         ST_K1: w_s_raddr = r_i;
         ST_K2: w_s_raddr = w_j_ksa;
         ST_K3: begin
            w_s_we    = 1'b1;
            w_s_waddr = r_i;
            w_s_wdata = r_s_rdata;
         end
         ST_K4: begin
            w_s_we    = 1'b1;
            w_s_waddr = r_j;
            w_s_wdata = r_si;
         end
         ST_L1: w_pt_addr = 8'd0;
         ST_L2: begin
            w_ct_wren   = 1'b1;
            w_ct_addr   = 8'd0;
            w_ct_wrdata = bus.pt_rddata;
         end
         ST_P1: w_s_raddr = w_i_inc;
         ST_P2: w_s_raddr = w_j_prga;
         ST_P3: begin
            w_s_we    = 1'b1;
            w_s_waddr = r_i;
            w_s_wdata = r_s_rdata;
         end
         ST_P4: begin
            w_s_we    = 1'b1;
            w_s_waddr = r_j;
            w_s_wdata = r_si;
            w_pt_addr = r_k;
         end
         ST_P5: w_s_raddr = w_pad_addr;
         ST_P6: begin
            w_ct_wren   = 1'b1;
            w_ct_addr   = r_k;
            w_ct_wrdata = r_s_rdata ^ r_pt;
         end
         default: ;
      endcase
   end

   // Datapath registers: key latch, indices, swap operands and plaintext byte.
   always_ff @(posedge clk) begin
      case (r_state)
         ST_IDLE: if (r_rdy && bus.en) begin
            r_key <= bus.key;
            r_i   <= 8'd0;
         end
         ST_INIT: begin
            r_i <= w_i_inc;
            if (r_i == 8'hFF) begin
               r_j    <= 8'd0;
               r_kidx <= 2'd0;
            end
         end
         ST_K2: begin
            r_si <= r_s_rdata;
            r_j  <= w_j_ksa;
         end
         ST_K4: begin
            r_i    <= w_i_inc;
            r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
         end
         ST_L2: begin
            r_len <= bus.pt_rddata;
            r_i   <= 8'd0;
            r_j   <= 8'd0;
            r_k   <= 8'd1;
         end
         ST_P1: r_i <= w_i_inc;
         ST_P2: begin
            r_si <= r_s_rdata;
            r_j  <= w_j_prga;
         end
         ST_P3: r_sj <= r_s_rdata;
         ST_P5: r_pt <= bus.pt_rddata;
         ST_P6: r_k  <= r_k + 8'd1;
         default: ;
      endcase
   end

   // S box storage: one write port, one registered read port.
   always_ff @(posedge clk) begin
      if (w_s_we) r_s[w_s_waddr] <= w_s_wdata;
      r_s_rdata <= r_s[w_s_raddr];
   end

   assign bus.rdy       = r_rdy;
   assign bus.pt_addr   = w_pt_addr;
   assign bus.ct_wren   = w_ct_wren;
   assign bus.ct_addr   = w_ct_addr;
   assign bus.ct_wrdata = w_ct_wrdata;

endmodule
